// File: rtl/instruction_cache_dm.sv
`default_nettype none
// ============================================================================
//  Module   : instruction_cache_dm
//  Purpose  : Direct-mapped instruction cache between the fetch stage and the
//             memory bus. A combinational tag/valid lookup serves hits in the
//             same cycle. A miss starts a line refill that reads one 32-bit
//             word per bus handshake. Fetch stalls while icache_r is low.
//  Ports    : CLK, reset        - clock / synchronous active-high reset
//             PC                - fetch address (PC[1:0] ignored)
//             flush             - invalidate every line, abandon any refill
//             icache_r          - hit, instruction valid this cycle
//             instruction       - fetched word on a hit, NOP_INSN otherwise
//             mem_req/mem_addr  - registered word read request to the bus
//             mem_ready         - bus handshake, mem_rdata valid this cycle
//             mem_rdata         - read data
//  Revision : 1.0 - initial release
// ============================================================================
module instruction_cache_dm #(
    parameter int          NUM_LINES  = 16,
    parameter int          LINE_WORDS = 4,
    parameter int          ADDR_W     = 64,
    parameter logic [31:0] NOP_INSN   = 32'h0000_0013
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic [ADDR_W-1:0] PC,
    input  logic              flush,
    output logic              icache_r,
    output logic [31:0]       instruction,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata
);

    localparam int BEAT_W = $clog2(LINE_WORDS);
    localparam int OFF_W  = BEAT_W + 2;
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_REFILL = 1'b1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [0:0]           state_q, state_d;
    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic [BEAT_W-1:0]    beat_q, beat_d;
    logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
    logic                 mem_req_q;

    // Tag and data arrays carry no reset; only valid bits are cleared.
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [31:0]          data_q [NUM_LINES][LINE_WORDS];

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [TAG_W-1:0]  w_pc_tag;
    logic [IDX_W-1:0]  w_pc_idx;
    logic [BEAT_W-1:0] w_pc_word;
    logic [TAG_W-1:0]  w_fill_tag;
    logic [IDX_W-1:0]  w_fill_idx;
    logic [BEAT_W-1:0] w_beat_inc;
    logic              w_lookup_hit;
    logic              w_miss_start;
    logic              w_beat_done;
    logic              w_last_beat;
    logic              unused_pc_bits;

    assign w_pc_tag  = PC[ADDR_W-1:IDX_W+OFF_W];
    assign w_pc_idx  = PC[IDX_W+OFF_W-1:OFF_W];
    assign w_pc_word = PC[OFF_W-1:2];

    // The request address register doubles as the latched line base: its
    // tag/index bits stay constant for the whole refill, only the word
    // select field steps with the beat counter.
    assign w_fill_tag = mem_addr_q[ADDR_W-1:IDX_W+OFF_W];
    assign w_fill_idx = mem_addr_q[IDX_W+OFF_W-1:OFF_W];

    assign w_beat_inc   = beat_q + BEAT_W'(1);
    assign w_lookup_hit = valid_q[w_pc_idx] && (tag_q[w_pc_idx] == w_pc_tag);
    assign w_miss_start = (state_q == S_IDLE) && !flush && !w_lookup_hit;
    assign w_beat_done  = (state_q == S_REFILL) && mem_ready && !flush;
    assign w_last_beat  = (beat_q == LAST_BEAT);

    // Byte offset within the word is not used by an instruction fetch.
    assign unused_pc_bits = ^PC[1:0];

    // ------------------------------------------------------------------
    // FSM: state register (mem_req registered alongside the state)
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q   <= S_IDLE;
            mem_req_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mem_req_q <= (state_d == S_REFILL);
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!w_lookup_hit) begin
                        state_d = S_REFILL;
                    end
                end
                S_REFILL: begin
                    if (mem_ready && w_last_beat) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs (hit path is purely combinational)
    // ------------------------------------------------------------------
    always_comb begin
        icache_r    = (state_q == S_IDLE) && !flush && w_lookup_hit;
        instruction = NOP_INSN;
        if (icache_r) begin
            instruction = data_q[w_pc_idx][w_pc_word];
        end
    end

    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;

    // ------------------------------------------------------------------
    // Refill datapath: beat counter, request address, valid bits
    // ------------------------------------------------------------------
    always_comb begin
        beat_d     = beat_q;
        mem_addr_d = mem_addr_q;
        valid_d    = valid_q;
        if (flush) begin
            valid_d = '0;
            beat_d  = '0;
        end else if (w_miss_start) begin
            beat_d     = '0;
            mem_addr_d = {PC[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        end else if (w_beat_done) begin
            // On the last beat the counter wraps to 0 and the address
            // returns to the line base; mem_req is low by then.
            beat_d     = w_beat_inc;
            mem_addr_d = {mem_addr_q[ADDR_W-1:OFF_W], w_beat_inc, 2'b00};
            if (w_last_beat) begin
                valid_d[w_fill_idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            beat_q     <= '0;
            mem_addr_q <= '0;
            valid_q    <= '0;
        end else begin
            beat_q     <= beat_d;
            mem_addr_q <= mem_addr_d;
            valid_q    <= valid_d;
        end
    end

    // ------------------------------------------------------------------
    // Tag / data arrays (written only by an accepted refill beat)
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!reset && w_beat_done) begin
            data_q[w_fill_idx][beat_q] <= mem_rdata;
            if (w_last_beat) begin
                tag_q[w_fill_idx] <= w_fill_tag;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instruction_cache_dm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instruction_cache_dm
//  Purpose  : Self-checking bench for instruction_cache_dm. Directed scenario
//             tasks plus a randomized run compared against a queue-based
//             behavioural cache model and an address-hashed memory.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_cache_dm;

    localparam int          NUM_LINES  = 16;
    localparam int          LINE_WORDS = 4;
    localparam int          ADDR_W     = 64;
    localparam logic [31:0] NOP        = 32'h0000_0013;
    localparam int          LB         = LINE_WORDS * 4;

    logic              CLK;
    logic              reset;
    logic [ADDR_W-1:0] PC;
    logic              flush;
    logic              icache_r;
    logic [31:0]       instruction;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ready;
    logic [31:0]       mem_rdata;

    instruction_cache_dm #(
        .NUM_LINES (NUM_LINES),
        .LINE_WORDS(LINE_WORDS),
        .ADDR_W    (ADDR_W),
        .NOP_INSN  (NOP)
    ) dut (
        .CLK        (CLK),
        .reset      (reset),
        .PC         (PC),
        .flush      (flush),
        .icache_r   (icache_r),
        .instruction(instruction),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // ------------------------------------------------------------------
    // Behavioural model: per-index valid bit and resident line base, plus
    // a queue of word addresses still to be fetched for the current fill.
    // ------------------------------------------------------------------
    bit          mvalid [NUM_LINES];
    logic [63:0] mline  [NUM_LINES];
    logic [63:0] pend [$];
    logic [63:0] fill_line;
    int          ready_mode;   // 0: always ready, 1: every 3rd request cycle, 2: random
    int          rc;
    int          n_checks;
    int          n_errors;
    logic        e_hit;
    logic [31:0] e_insn;
    logic        e_req;
    logic [63:0] e_addr;

    function automatic logic [63:0] line_of(input logic [63:0] a);
        return a & ~64'(LB - 1);
    endfunction

    function automatic int idx_of(input logic [63:0] a);
        return int'((a / LB) % NUM_LINES);
    endfunction

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        logic [63:0] w;
        w = a;
        return (w[31:0] * 32'h9E37_79B1) ^ w[63:32] ^ 32'h1234_5678;
    endfunction

    function automatic bit model_hit();
        int i;
        i = idx_of(PC);
        return (pend.size() == 0) && !flush && mvalid[i] && (mline[i] == line_of(PC));
    endfunction

    task automatic model_step();
        if (reset || flush) begin
            foreach (mvalid[i]) mvalid[i] = 1'b0;
            pend.delete();
        end else if (pend.size() == 0) begin
            if (!model_hit()) begin
                fill_line = line_of(PC);
                for (int k = 0; k < LINE_WORDS; k++) pend.push_back(fill_line + 64'(4 * k));
            end
        end else if (mem_ready) begin
            void'(pend.pop_front());
            if (pend.size() == 0) begin
                mvalid[idx_of(fill_line)] = 1'b1;
                mline[idx_of(fill_line)]  = fill_line;
            end
        end
    endtask

    task automatic model_expect();
        e_hit  = model_hit();
        e_insn = e_hit ? mem_word({PC[63:2], 2'b00}) : NOP;
        e_req  = (pend.size() != 0);
        e_addr = e_req ? pend[0] : 64'h0;
    endtask

    // One clock: advance the model on the edge, then act as the memory.
    task automatic tick();
        @(posedge CLK);
        model_step();
        #1;
        case (ready_mode)
            0: mem_ready = 1'b1;
            1: begin
                if (pend.size() != 0) begin
                    mem_ready = (rc % 3 == 2);
                    rc++;
                end else begin
                    mem_ready = 1'b0;
                    rc = 0;
                end
            end
            default: mem_ready = 1'($urandom_range(0, 1));
        endcase
        mem_rdata = mem_word(mem_addr);
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        PC    = 64'h0;
        @(negedge CLK);
        n_checks++; if (mem_req !== 1'b0) begin n_errors++; $display("FAIL reset_mem_req: got %0b expected 0", mem_req); end
        n_checks++; if (mem_addr !== 64'h0) begin n_errors++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
        n_checks++; if (icache_r !== 1'b0) begin n_errors++; $display("FAIL reset_icache_r: got %0b expected 0", icache_r); end
        n_checks++; if (instruction !== NOP) begin n_errors++; $display("FAIL reset_insn: got %h expected %h", instruction, NOP); end
    endtask

    // Starts in the cycle where PC=0 is first presented after reset.
    task automatic test_cold_miss();
        ready_mode = 0;
        for (int k = 0; k < LINE_WORDS; k++) begin
            tick();
            @(negedge CLK);
            n_checks++; if (mem_req !== 1'b1 || mem_addr !== 64'(4 * k)) begin n_errors++; $display("FAIL cold_beat%0d: got req=%0b addr=%h expected req=1 addr=%h", k, mem_req, mem_addr, 64'(4 * k)); end
            n_checks++; if (icache_r !== 1'b0) begin n_errors++; $display("FAIL cold_stall%0d: got icache_r=%0b expected 0", k, icache_r); end
        end
        tick();
        @(negedge CLK);
        n_checks++; if (icache_r !== 1'b1 || instruction !== mem_word(64'h0)) begin n_errors++; $display("FAIL cold_hit: got r=%0b insn=%h expected r=1 insn=%h", icache_r, instruction, mem_word(64'h0)); end
        n_checks++; if (mem_req !== 1'b0) begin n_errors++; $display("FAIL cold_req_drop: got %0b expected 0", mem_req); end
    endtask

    task automatic test_same_line();
        logic [63:0] addrs [2];
        addrs[0] = 64'h8;
        addrs[1] = 64'hC;
        foreach (addrs[j]) begin
            tick();
            PC = addrs[j];
            @(negedge CLK);
            n_checks++; if (icache_r !== 1'b1 || instruction !== mem_word(addrs[j])) begin n_errors++; $display("FAIL same_line_%h: got r=%0b insn=%h expected r=1 insn=%h", addrs[j], icache_r, instruction, mem_word(addrs[j])); end
            n_checks++; if (mem_req !== 1'b0) begin n_errors++; $display("FAIL same_line_req_%h: got %0b expected 0", addrs[j], mem_req); end
        end
    endtask

    task automatic test_conflict();
        logic [63:0] bases [2];
        ready_mode = 0;
        bases[0] = 64'h100;
        bases[1] = 64'h0;
        foreach (bases[j]) begin
            tick();
            PC = bases[j];
            @(negedge CLK);
            n_checks++; if (icache_r !== 1'b0) begin n_errors++; $display("FAIL conflict_miss_%h: got %0b expected 0", bases[j], icache_r); end
            for (int k = 0; k < LINE_WORDS; k++) begin
                tick();
                @(negedge CLK);
                n_checks++; if (mem_req !== 1'b1 || mem_addr !== bases[j] + 64'(4 * k)) begin n_errors++; $display("FAIL conflict_addr_%h_%0d: got req=%0b addr=%h expected req=1 addr=%h", bases[j], k, mem_req, mem_addr, bases[j] + 64'(4 * k)); end
            end
            tick();
            @(negedge CLK);
            n_checks++; if (icache_r !== 1'b1 || instruction !== mem_word(bases[j])) begin n_errors++; $display("FAIL conflict_hit_%h: got r=%0b insn=%h expected r=1 insn=%h", bases[j], icache_r, instruction, mem_word(bases[j])); end
        end
    endtask

    task automatic test_wait_states();
        logic [63:0] exp;
        ready_mode = 1;
        rc = 0;
        tick();
        PC = 64'h40;
        @(negedge CLK);
        n_checks++; if (icache_r !== 1'b0) begin n_errors++; $display("FAIL wait_miss: got %0b expected 0", icache_r); end
        for (int c = 1; c <= 12; c++) begin
            tick();
            @(negedge CLK);
            exp = 64'h40 + 64'(4 * ((c - 1) / 3));
            n_checks++; if (mem_req !== 1'b1 || mem_addr !== exp || icache_r !== 1'b0) begin n_errors++; $display("FAIL wait_cycle%0d: got req=%0b addr=%h r=%0b expected req=1 addr=%h r=0", c, mem_req, mem_addr, icache_r, exp); end
        end
        tick();
        @(negedge CLK);
        n_checks++; if (icache_r !== 1'b1 || instruction !== mem_word(64'h40)) begin n_errors++; $display("FAIL wait_hit13: got r=%0b insn=%h expected r=1 insn=%h", icache_r, instruction, mem_word(64'h40)); end
        ready_mode = 0;
    endtask

    task automatic test_flush_mid_refill();
        ready_mode = 0;
        tick();
        PC = 64'h80;
        @(negedge CLK);
        n_checks++; if (icache_r !== 1'b0 || instruction !== NOP) begin n_errors++; $display("FAIL flush_pre_miss: got r=%0b insn=%h expected r=0 insn=%h", icache_r, instruction, NOP); end
        tick();
        tick();
        tick();
        flush = 1'b1;
        @(negedge CLK);
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== 64'h88) begin n_errors++; $display("FAIL flush_beat2: got req=%0b addr=%h expected req=1 addr=88", mem_req, mem_addr); end
        tick();
        flush = 1'b0;
        PC    = 64'h0;
        @(negedge CLK);
        n_checks++; if (mem_req !== 1'b0) begin n_errors++; $display("FAIL flush_req_drop: got %0b expected 0", mem_req); end
        n_checks++; if (icache_r !== 1'b0) begin n_errors++; $display("FAIL flush_line0_invalid: got %0b expected 0", icache_r); end
        tick();
        @(negedge CLK);
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== 64'h0) begin n_errors++; $display("FAIL flush_restart: got req=%0b addr=%h expected req=1 addr=0", mem_req, mem_addr); end
        for (int k = 0; k < LINE_WORDS; k++) tick();
        @(negedge CLK);
        n_checks++; if (icache_r !== 1'b1 || instruction !== mem_word(64'h0)) begin n_errors++; $display("FAIL flush_refill_hit: got r=%0b insn=%h expected r=1 insn=%h", icache_r, instruction, mem_word(64'h0)); end
    endtask

    task automatic test_reset_mid_refill();
        ready_mode = 0;
        tick();
        PC = 64'hC0;
        @(negedge CLK);
        n_checks++; if (icache_r !== 1'b0) begin n_errors++; $display("FAIL rst_pre_miss: got %0b expected 0", icache_r); end
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        PC    = 64'h0;
        @(negedge CLK);
        n_checks++; if (mem_req !== 1'b0) begin n_errors++; $display("FAIL rst_req_drop: got %0b expected 0", mem_req); end
        n_checks++; if (icache_r !== 1'b0 || instruction !== NOP) begin n_errors++; $display("FAIL rst_line0_invalid: got r=%0b insn=%h expected r=0 insn=%h", icache_r, instruction, NOP); end
        for (int k = 0; k <= LINE_WORDS; k++) tick();
        @(negedge CLK);
        n_checks++; if (icache_r !== 1'b1 || instruction !== mem_word(64'h0)) begin n_errors++; $display("FAIL rst_refill_hit: got r=%0b insn=%h expected r=1 insn=%h", icache_r, instruction, mem_word(64'h0)); end
    endtask

    task automatic test_random();
        int r;
        logic [63:0] hi;
        ready_mode = 2;
        for (int i = 0; i < 800; i++) begin
            tick();
            reset = ($urandom_range(0, 149) == 0);
            flush = ($urandom_range(0, 29) == 0);
            r = $urandom_range(0, 7);
            if (r == 0) begin
                hi = ($urandom_range(0, 3) == 0) ? 64'hFFFF_0000_0000_0000 : 64'h0;
                PC = hi | 64'($urandom_range(0, 1023));
            end else if (r == 1) begin
                PC = line_of(PC) | 64'($urandom_range(0, LB - 1));
            end
            @(negedge CLK);
            model_expect();
            n_checks++; if (icache_r !== e_hit) begin n_errors++; $display("FAIL rand%0d_hit: pc=%h got %0b expected %0b", i, PC, icache_r, e_hit); end
            n_checks++; if (instruction !== e_insn) begin n_errors++; $display("FAIL rand%0d_insn: pc=%h got %h expected %h", i, PC, instruction, e_insn); end
            n_checks++; if (mem_req !== e_req) begin n_errors++; $display("FAIL rand%0d_req: got %0b expected %0b", i, mem_req, e_req); end
            if (e_req) begin
                n_checks++; if (mem_addr !== e_addr) begin n_errors++; $display("FAIL rand%0d_addr: got %h expected %h", i, mem_addr, e_addr); end
            end
        end
        reset = 1'b0;
        flush = 1'b0;
        ready_mode = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected normal completion");
        $fatal(1, "simulation timeout");
    end

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        ready_mode = 0;
        rc         = 0;
        reset      = 1'b1;
        flush      = 1'b0;
        PC         = 64'h0;
        mem_ready  = 1'b0;
        mem_rdata  = 32'h0;
        foreach (mvalid[i]) begin
            mvalid[i] = 1'b0;
            mline[i]  = 64'h0;
        end
        fill_line = 64'h0;

        test_reset();
        test_cold_miss();
        test_same_line();
        test_conflict();
        test_wait_states();
        test_flush_mid_refill();
        test_reset_mid_refill();
        test_random();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instruction_cache_dm.md
# instruction_cache_dm

Parametrised direct-mapped instruction cache sitting between the fetch stage and the memory bus. It replaces the always-hit fetch memory with real tag/valid lookup. Misses trigger a line refill FSM that reads one 32-bit word per bus handshake. The fetch-side interface (`PC` in; `icache_r`, `instruction` out) is unchanged, so fetch stalls while `icache_r` is low.

## Interface
- `NUM_LINES`, 16, number of cache lines; power of two, ≥2
- `LINE_WORDS`, 4, 32-bit words per line; power of two, ≥2
- `ADDR_W`, 64, address width
- `NOP_INSN`, 32'h00000013, value driven on `instruction` when not hitting

- `CLK`  in  1  clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `PC`  in  ADDR_W  fetch address; `PC[1:0]` ignored
- `flush`  in  1  invalidate all lines (e.g. fence.i)
- `icache_r`  out  1  hit: `instruction` valid this cycle
- `instruction`  out  32  fetched word when `icache_r`=1, else `NOP_INSN`
- `mem_req`  out  1  word read request to the bus
- `mem_addr`  out  ADDR_W  word address of the request, 4-byte aligned
- `mem_ready`  in  1  bus accepted the request; `mem_rdata` valid this cycle
- `mem_rdata`  in  32  read data

## Operation
- Address split: `OFF = log2(LINE_WORDS)+2` bits of offset (word select = `PC[OFF-1:2]`), `IDX = log2(NUM_LINES)` bits of index, `TAG = ADDR_W-IDX-OFF` bits of tag.
- Storage: per line, a valid bit, a tag and `LINE_WORDS` data words. Valid bits are flops cleared by reset. Data and tag arrays carry no reset.
- Hit (combinational): state IDLE, `valid[idx]`, and `tag[idx]==PC tag`. Then `icache_r`=1 and `instruction`=data[idx][word].
- FSM states:
  - IDLE: on a miss (and no `flush`), latch the line base (`PC` with offset bits zeroed) and idx, clear the beat counter, and go to REFILL.
  - REFILL: `mem_req`=1 and `mem_addr`=base + 4·beat. Each cycle with `mem_ready`=1, write `mem_rdata` into data[idx][beat] and increment beat. On the last beat (`beat==LINE_WORDS-1`), also write the tag, set valid and return to IDLE.
  - While `mem_ready`=0, `mem_req` and `mem_addr` hold stable.
- `icache_r`=0 throughout REFILL.
- The refill always completes for the latched line, even if `PC` changes mid-refill. The next lookup after return to IDLE uses the current `PC`.
- `flush` takes precedence in any state: all valid bits clear at the next edge, and the FSM goes to IDLE with `mem_req`=0.
  - A refill abandoned by flush leaves the line invalid.
  - The bus must tolerate `mem_req` dropping without `mem_ready`.
- While `flush`=1 in IDLE, `icache_r` is forced to 0 and no refill starts.
- A refill overwrites the line regardless of its prior contents; a conflict miss evicts the old line.

## Timing
- Reset values:
  - state IDLE, beat 0
  - all valid bits 0
  - `mem_req` 0, `mem_addr` 0
  - `icache_r` 0 (every lookup misses), `instruction` = `NOP_INSN`
- Reset during REFILL aborts it exactly like `flush`. `mem_req` is 0 in the cycle after reset is sampled.
- Hit latency: 0 cycles. Outputs are combinational from `PC` and the array contents.
- Miss penalty with zero-wait memory (`mem_ready` tied 1):
  - miss seen in cycle 0
  - beats in cycles 1..`LINE_WORDS`
  - hit in cycle `LINE_WORDS`+1
- Each memory wait cycle adds one cycle to the penalty.
- `mem_addr` and `mem_req` are registered outputs.

## Test plan
- Cold miss: reset, `PC`=0, memory ready every cycle, `LINE_WORDS`=4.
  - `mem_addr` = 0, 4, 8, C in cycles 1-4.
  - `icache_r`=1 in cycle 5, with `instruction` = word at 0.
- Same-line hits: after the fill, `PC`=8 then `PC`=C. Each gives `icache_r`=1 in the same cycle with the correct word, and `mem_req` stays 0.
- Conflict (16×4 config): fill 0x0, then `PC`=0x100.
  - Miss; refill at 0x100-0x10C.
  - Returning to `PC`=0x0 misses again and refills.
- Wait states: `mem_ready` high only every 3rd cycle.
  - `mem_addr` is held across wait cycles.
  - Hit arrives in cycle 13 after the miss.
- Flush mid-refill: `flush` pulsed during beat 2.
  - `mem_req`=0 next cycle.
  - `PC`=0 then misses and restarts a refill from address 0.
- Reset mid-refill: `reset` asserted during beat 1.
  - Next cycle `mem_req`=0 and `icache_r`=0.
  - Previously valid lines now miss.
